chan_mux_rr: RTL and testbench
==============================

# chan_mux_rr

Registered, parametrised N-channel multiplexer with valid/ready handshaking and two selection modes: fixed select and round-robin scan. It merges several producer streams of equal width onto one consumer port, so a datapath needs no hand-written per-width select trees. It sits between multiple producers and a single shared consumer. It adds one register stage and honours consumer backpressure.

## Interface
- CHANNELS, 4, number of input channels (2..16); select width SW = clog2(CHANNELS), internal localparam
- WIDTH, 8, data width per channel (1..64)
- clk  in  1  rising-edge clock, single domain
- rst_n  in  1  reset, synchronous, active-low
- in_data  in  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- in_valid  in  CHANNELS  per-channel valid
- in_ready  out  CHANNELS  one-hot accept strobe to the granted channel, combinational
- mode  in  1  0 = fixed select, 1 = round-robin scan
- sel  in  SW  channel index used in fixed mode
- out_data  out  WIDTH  registered selected data
- out_ch  out  SW  registered index of the channel that produced out_data
- out_valid  out  1  registered valid
- out_ready  in  1  consumer ready
- out_parity  out  1  present only with MUX_PARITY_EN (see Configuration)

## Operation
- Reset (rst_n low at a clk edge) clears these registers: out_data=0, out_ch=0, out_valid=0, round-robin pointer ptr=0, out_parity=0.
- While rst_n is low, in_ready is forced to all zeros.
- Load condition: load = !out_valid || out_ready. The output register accepts new data only when load is 1.
- Fixed mode (mode=0):
  - The candidate is channel sel.
  - A grant occurs if load, sel < CHANNELS and in_valid[sel] are all true.
  - If sel >= CHANNELS there is no grant, and out_valid drops once the current word is taken.
- Round-robin mode (mode=1):
  - Search starts at ptr and wraps modulo CHANNELS. The first k with in_valid[k]=1 is granted, provided load is true.
  - On a grant, ptr <= (k+1) mod CHANNELS, which wraps from CHANNELS-1 to 0.
  - With no valid channel, ptr holds.
- ptr advances only on grants made in mode=1. It keeps its value across fixed-mode periods and is not cleared on a mode switch.
- On a grant to channel k:
  - in_ready[k]=1 in that cycle.
  - At the next edge: out_data <= channel k data, out_ch <= k, out_valid <= 1.
- No grant while load is true: out_valid <= 0 at the next edge. out_data and out_ch hold their previous values.
- Stall (out_valid && !out_ready): all output registers hold, and in_ready is all zeros.
- mode and sel are sampled every cycle. A change affects the grant in the same cycle and never corrupts a word already registered.

## Timing
- Latency is 1 cycle: a grant at edge n produces out_valid at edge n+1.
- Sustained throughput is 1 word/cycle while out_ready=1 and a valid channel exists.
- in_ready is combinational from in_valid, mode, sel, ptr, out_valid and out_ready. There are no combinational paths from in_data to any output.
- Simultaneous out_ready=1 and a new grant in the same cycle: the held word is consumed and the new word is loaded at the same edge, with no bubble.
- Reset mid-transfer: a registered word is discarded, out_valid=0 after that edge, and any grant in that cycle is cancelled (in_ready=0).

## Configuration
- MUX_PARITY_EN defined:
  - Adds the output port out_parity.
  - out_parity is the registered even parity (XOR reduction) of the data being loaded and updates together with out_data.
  - Reset value is 0.
- MUX_PARITY_EN undefined: the port and its logic are absent, and all other behaviour is identical.

## Test plan
- Reset then idle: hold rst_n=0 for 2 cycles with in_valid=4'b1111 -> out_valid=0, out_data=0, out_ch=0, in_ready=0. After release, the first word appears 1 cycle later.
- Fixed mode: CHANNELS=4, WIDTH=8, mode=0, sel=2, in_data ch2=8'hA5, in_valid=4'b0100, out_ready=1 -> in_ready=4'b0100, next cycle out_data=8'hA5, out_ch=2, out_valid=1. Same setup with in_valid=4'b1011 -> no grant, out_valid=0.
- Round-robin fairness: mode=1, in_valid=4'b1111 held, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 with one word per cycle. Then in_valid=4'b1001 -> grants alternate 0,3 with wrap.
- Backpressure: word for ch1=8'h3C registered, out_ready=0 for 3 cycles -> out_data=8'h3C, out_valid=1 and in_ready=0 throughout, ptr unchanged. out_ready=1 -> next grant in the same cycle, no bubble.
- Mode switch and out-of-range select (CHANNELS=3): mode=1 grants ch0, switch to mode=0 with sel=3 -> no grants and out_valid falls. Return to mode=1 -> search resumes at ptr=1.
- Parity build (MUX_PARITY_EN): out_data=8'h07 -> out_parity=1. out_data=8'h03 -> out_parity=0. Reset -> out_parity=0.

Source files
------------

// File: rtl/chan_mux_rr_if.sv
`default_nettype none
// ============================================================================
//  Module      : chan_mux_rr_if
//  Description : Bundle of producer-side and consumer-side stream signals
//                for chan_mux_rr.
//                master - the multiplexer's view (drives in_ready, out_*)
//                slave  - the environment's view (drives in_*, out_ready)
//                Ports carried: in_data, in_valid, in_ready, out_data,
//                out_ch, out_valid, out_ready, out_parity (MUX_PARITY_EN only)
//  Options     : MUX_PARITY_EN adds out_parity
//  Revision    : 1.0 - initial release
// ============================================================================
interface chan_mux_rr_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
);
  localparam int SW = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [WIDTH-1:0]          out_data;
  logic [SW-1:0]             out_ch;
  logic                      out_valid;
  logic                      out_ready;
`ifdef MUX_PARITY_EN
  logic                      out_parity;

  modport master (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid, out_parity
  );
  modport slave (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid, out_parity
  );
`else
  modport master (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );
  modport slave (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );
`endif
endinterface
`default_nettype wire

// File: rtl/chan_mux_rr.sv
`default_nettype none
// ============================================================================
//  Module      : chan_mux_rr
//  Description : Registered N-channel stream multiplexer with valid/ready
//                handshake. mode=0 forwards the channel given by sel,
//                mode=1 scans channels round-robin from an internal pointer.
//                One output register stage; consumer backpressure honoured.
//  Ports       : clk   - rising-edge clock
//                rst_n - synchronous active-low reset
//                mode  - 0 fixed select, 1 round-robin
//                sel   - channel index for fixed mode
//                bus   - chan_mux_rr_if.master (in_data/in_valid/in_ready,
//                        out_data/out_ch/out_valid/out_ready[/out_parity])
//  Options     : MUX_PARITY_EN - registered even parity of out_data
//  Revision    : 1.0 - initial release
// ============================================================================
module chan_mux_rr #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
) (
  input  wire logic                        clk,
  input  wire logic                        rst_n,
  input  wire logic                        mode,
  input  wire logic [$clog2(CHANNELS)-1:0] sel,
  chan_mux_rr_if.master                    bus
);
  localparam int SW = $clog2(CHANNELS);
  localparam int c_slots = 1 << SW;
  localparam logic [SW:0]   c_num_ch = (SW+1)'(CHANNELS);
  localparam logic [SW-1:0] c_last   = SW'(CHANNELS - 1);

  logic [WIDTH-1:0]    r_out_data;
  logic [SW-1:0]       r_out_ch;
  logic                r_out_valid;
  logic [SW-1:0]       r_ptr;

  logic                w_load;
  logic [c_slots-1:0]  w_valid_pad;
  logic [WIDTH-1:0]    w_ch_data [c_slots];
  logic                w_fix_ok;
  logic                w_rr_found;
  logic [SW-1:0]       w_rr_idx;
  logic                w_grant;
  logic [SW-1:0]       w_idx;
  logic [SW-1:0]       w_next_ptr;

  // Pad lanes up to a power of two so any sel value indexes safely; padded
  // lanes are never valid and never granted.
  generate
    for (genvar k = 0; k < c_slots; k++) begin : g_lane
      if (k < CHANNELS) begin : g_used
        assign w_valid_pad[k] = bus.in_valid[k];
        assign w_ch_data[k]   = bus.in_data[k*WIDTH +: WIDTH];
      end else begin : g_pad
        assign w_valid_pad[k] = 1'b0;
        assign w_ch_data[k]   = '0;
      end
    end
  endgenerate

  assign w_load   = !r_out_valid || bus.out_ready;
  assign w_fix_ok = ({1'b0, sel} < c_num_ch) && w_valid_pad[sel];

  // Round-robin search: walk offsets from the farthest back to zero so the
  // channel closest to ptr (in wrap order) is the one left selected.
  always_comb begin : p_rr_search
    logic [SW:0] v_sum;
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    v_sum      = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      v_sum = {1'b0, r_ptr} + (SW+1)'(i);
      if (v_sum >= c_num_ch) begin
        v_sum = v_sum - c_num_ch;
      end
      if (w_valid_pad[v_sum[SW-1:0]]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = v_sum[SW-1:0];
      end
    end
  end

  assign w_grant    = rst_n && w_load && (mode ? w_rr_found : w_fix_ok);
  assign w_idx      = mode ? w_rr_idx : sel;
  assign w_next_ptr = (w_rr_idx == c_last) ? '0 : w_rr_idx + 1'b1;

  assign bus.in_ready = w_grant ? (CHANNELS'(1) << w_idx) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_valid <= 1'b0;
      r_ptr       <= '0;
    end else begin
      // A grant implies load; with load and no grant the word is dropped.
      if (w_load) begin
        r_out_valid <= w_grant;
      end
      if (w_grant) begin
        r_out_data <= w_ch_data[w_idx];
        r_out_ch   <= w_idx;
      end
      // The pointer only moves on round-robin grants; fixed-mode traffic
      // leaves it where it was.
      if (w_grant && mode) begin
        r_ptr <= w_next_ptr;
      end
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_ch    = r_out_ch;
  assign bus.out_valid = r_out_valid;

`ifdef MUX_PARITY_EN
  logic r_out_parity;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_parity <= 1'b0;
    end else if (w_grant) begin
      r_out_parity <= ^w_ch_data[w_idx];
    end
  end

  assign bus.out_parity = r_out_parity;
`endif

endmodule
`default_nettype wire

// File: tb/tb_chan_mux_rr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_chan_mux_rr
//  Description : Directed self-checking bench for chan_mux_rr. A 4-channel
//                instance covers reset, fixed select, round-robin fairness,
//                backpressure and reset mid-transfer; a 3-channel instance
//                covers out-of-range select, mode switching and pointer wrap.
//                Parity checks are built when MUX_PARITY_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_chan_mux_rr;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode4;
  logic [1:0] sel4;
  logic       mode3;
  logic [1:0] sel3;
  logic [7:0] d4 [4];
  logic [7:0] d3 [3];
  int         n_checks = 0;
  int         n_errors = 0;
  int         exp_ch;
  int         alt_seq [4];

  always #5 clk = ~clk;

  chan_mux_rr_if #(.CHANNELS(4), .WIDTH(8)) bus4 ();
  chan_mux_rr_if #(.CHANNELS(3), .WIDTH(8)) bus3 ();

  assign bus4.in_data = {d4[3], d4[2], d4[1], d4[0]};
  assign bus3.in_data = {d3[2], d3[1], d3[0]};

  chan_mux_rr #(.CHANNELS(4), .WIDTH(8)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (mode4),
    .sel   (sel4),
    .bus   (bus4)
  );

  chan_mux_rr #(.CHANNELS(3), .WIDTH(8)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (mode3),
    .sel   (sel3),
    .bus   (bus3)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    mode4 = 1'b1;
    sel4  = 2'd0;
    mode3 = 1'b1;
    sel3  = 2'd0;
    d4[0] = 8'h11; d4[1] = 8'h22; d4[2] = 8'hA5; d4[3] = 8'h44;
    d3[0] = 8'h10; d3[1] = 8'h21; d3[2] = 8'h32;
    bus4.in_valid  = 4'b1111;
    bus4.out_ready = 1'b1;
    bus3.in_valid  = 3'b000;
    bus3.out_ready = 1'b1;

    // Reset held two cycles with all channels valid
    settle;
    check("rst_ready_comb", 64'(bus4.in_ready), 64'h0);
    tick;
    tick;
    check("rst_valid", 64'(bus4.out_valid), 64'h0);
    check("rst_data",  64'(bus4.out_data),  64'h0);
    check("rst_ch",    64'(bus4.out_ch),    64'h0);
    check("rst_ready", 64'(bus4.in_ready),  64'h0);
`ifdef MUX_PARITY_EN
    check("rst_parity", 64'(bus4.out_parity), 64'h0);
`endif

    // Fixed mode, sel=2, only ch2 valid
    rst_n = 1'b1;
    mode4 = 1'b0;
    sel4  = 2'd2;
    bus4.in_valid = 4'b0100;
    settle;
    check("fix_ready", 64'(bus4.in_ready), 64'h4);
    tick;
    check("fix_data",  64'(bus4.out_data),  64'hA5);
    check("fix_ch",    64'(bus4.out_ch),    64'h2);
    check("fix_valid", 64'(bus4.out_valid), 64'h1);

    // Fixed mode, selected channel not valid
    bus4.in_valid = 4'b1011;
    settle;
    check("fix_nogrant_ready", 64'(bus4.in_ready), 64'h0);
    tick;
    check("fix_nogrant_valid", 64'(bus4.out_valid), 64'h0);
    check("fix_nogrant_hold",  64'(bus4.out_data),  64'hA5);

    // Round-robin, all valid: 0,1,2,3,0,1
    mode4 = 1'b1;
    bus4.in_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      exp_ch = i % 4;
      settle;
      check("rr_ready", 64'(bus4.in_ready), 64'(1 << exp_ch));
      tick;
      check("rr_ch",    64'(bus4.out_ch),    64'(exp_ch));
      check("rr_data",  64'(bus4.out_data),  64'(d4[exp_ch]));
      check("rr_valid", 64'(bus4.out_valid), 64'h1);
    end

    // Round-robin over ch0/ch3 from ptr=2: 3,0,3,0
    alt_seq = '{3, 0, 3, 0};
    bus4.in_valid = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      settle;
      check("alt_ready", 64'(bus4.in_ready), 64'(1 << alt_seq[i]));
      tick;
      check("alt_ch", 64'(bus4.out_ch), 64'(alt_seq[i]));
    end

    // Backpressure: register ch1=3C (ptr=1), then stall three cycles
    d4[1] = 8'h3C;
    bus4.in_valid = 4'b0010;
    settle;
    check("bp_load_ready", 64'(bus4.in_ready), 64'h2);
    tick;
    check("bp_load_data", 64'(bus4.out_data), 64'h3C);
    bus4.out_ready = 1'b0;
    bus4.in_valid  = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      settle;
      check("bp_stall_ready", 64'(bus4.in_ready),  64'h0);
      tick;
      check("bp_stall_data",  64'(bus4.out_data),  64'h3C);
      check("bp_stall_ch",    64'(bus4.out_ch),    64'h1);
      check("bp_stall_valid", 64'(bus4.out_valid), 64'h1);
    end
    // Release: ptr still 2, so ch2 is granted in the same cycle
    bus4.out_ready = 1'b1;
    settle;
    check("bp_release_ready", 64'(bus4.in_ready), 64'h4);
    tick;
    check("bp_release_ch",    64'(bus4.out_ch),    64'h2);
    check("bp_release_data",  64'(bus4.out_data),  64'hA5);
    check("bp_release_valid", 64'(bus4.out_valid), 64'h1);

    // Reset mid-transfer
    rst_n = 1'b0;
    settle;
    check("midrst_ready", 64'(bus4.in_ready), 64'h0);
    tick;
    check("midrst_valid", 64'(bus4.out_valid), 64'h0);
    check("midrst_data",  64'(bus4.out_data),  64'h0);
    check("midrst_ch",    64'(bus4.out_ch),    64'h0);
    rst_n = 1'b1;
    bus4.in_valid = 4'b0000;

`ifdef MUX_PARITY_EN
    check("par_after_rst", 64'(bus4.out_parity), 64'h0);
    mode4 = 1'b0;
    sel4  = 2'd0;
    d4[0] = 8'h07;
    bus4.in_valid = 4'b0001;
    tick;
    check("par_07_data", 64'(bus4.out_data),   64'h07);
    check("par_07",      64'(bus4.out_parity), 64'h1);
    d4[0] = 8'h03;
    tick;
    check("par_03", 64'(bus4.out_parity), 64'h0);
    bus4.in_valid = 4'b0000;
`endif

    // Three channels: RR grant ch0, then fixed sel=3 (out of range)
    mode3 = 1'b1;
    bus3.in_valid = 3'b001;
    settle;
    check("c3_rr0_ready", 64'(bus3.in_ready), 64'h1);
    tick;
    check("c3_rr0_ch",    64'(bus3.out_ch),    64'h0);
    check("c3_rr0_valid", 64'(bus3.out_valid), 64'h1);
    mode3 = 1'b0;
    sel3  = 2'd3;
    bus3.in_valid = 3'b111;
    settle;
    check("c3_oor_ready", 64'(bus3.in_ready), 64'h0);
    tick;
    check("c3_oor_valid", 64'(bus3.out_valid), 64'h0);
    check("c3_oor_hold",  64'(bus3.out_ch),    64'h0);
    // Back to RR: search resumes at ptr=1
    mode3 = 1'b1;
    settle;
    check("c3_resume_ready", 64'(bus3.in_ready), 64'h2);
    tick;
    check("c3_resume_ch",   64'(bus3.out_ch),   64'h1);
    check("c3_resume_data", 64'(bus3.out_data), 64'h21);
    // ptr=2 with ch0/ch2 valid: ch2 then wrap to ch0
    bus3.in_valid = 3'b101;
    settle;
    check("c3_wrap2_ready", 64'(bus3.in_ready), 64'h4);
    tick;
    check("c3_wrap2_ch", 64'(bus3.out_ch), 64'h2);
    settle;
    check("c3_wrap0_ready", 64'(bus3.in_ready), 64'h1);
    tick;
    check("c3_wrap0_ch",   64'(bus3.out_ch),   64'h0);
    check("c3_wrap0_data", 64'(bus3.out_data), 64'h10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
